btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, CLK cycles per sample tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter STABLE_TICKS, default 20, consecutive equal samples needed to accept a level change; legal range 2..255.
REQ-003 SHALL have port CLK  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port btn_raw  input  4  raw pushbuttons, active-low, asynchronous to CLK.
REQ-006 SHALL have port btn_db  output  4  debounced button levels, active-low, same polarity as btn_raw.
REQ-007 SHALL have port btn_press  output  4  one-CLK pulse per accepted press, active-high.
REQ-008 SHALL have port btn_sel  output  4  latched one-cold code of the last accepted press (1110/1101/1011/0111); this is the selection word for the downstream display stage.

Function
REQ-009 SHALL pass each btn_raw bit through a two-flop synchroniser before any other use.
REQ-010 SHALL run a prescaler 0..TICK_DIV-1 that asserts an internal tick for one CLK cycle when it wraps to 0; sampling happens only on tick cycles.
REQ-011 SHALL run an independent FSM per channel with states RELEASED, PRESS_CHK, PRESSED and RELEASE_CHK, plus an 8-bit stability counter.
REQ-012 RELEASED: a tick with synced=0 SHALL clear the counter to 1 and go to PRESS_CHK; a tick with synced=1 SHALL stay in RELEASED.
REQ-013 PRESS_CHK: a tick with synced=0 SHALL increment the counter; when the counter reaches STABLE_TICKS the FSM SHALL go to PRESSED; a tick with synced=1 SHALL return to RELEASED with no output change.
REQ-014 PRESSED and RELEASE_CHK SHALL mirror REQ-012 and REQ-013 with polarity inverted; reaching STABLE_TICKS in RELEASE_CHK SHALL return the FSM to RELEASED.
REQ-015 btn_db[i] SHALL be 0 exactly while channel i is in PRESSED or RELEASE_CHK, and registered.
REQ-016 btn_press[i] SHALL pulse high for exactly one CLK cycle, on the cycle after the tick that enters PRESSED.
REQ-017 Any glitch shorter than STABLE_TICKS ticks SHALL produce no change on btn_db, btn_press or btn_sel.
REQ-018 On a cycle with any btn_press bit set, btn_sel SHALL load ~(1<<i) for the lowest such i; simultaneous presses resolve to the lowest index.
REQ-019 btn_sel SHALL hold its value with all buttons released; a release SHALL NOT change btn_sel.
REQ-020 Worst-case press latency SHALL be 2 + STABLE_TICKS*TICK_DIV + 1 CLK cycles from a stable btn_raw edge.

Reset
REQ-021 While RST=1: all FSMs SHALL be in RELEASED, counters and prescaler 0, synchroniser flops 1, btn_db=4'b1111, btn_press=4'b0000, btn_sel=4'b1110.
REQ-022 Asserting RST mid-debounce SHALL abandon the check; after release, a button still held SHALL need a full STABLE_TICKS run and SHALL then pulse btn_press.

Configuration
REQ-023 With macro BTN_DEBOUNCE_AUTOREPEAT_EN defined, a channel held in PRESSED SHALL pulse btn_press again after 500 ticks, then every 100 ticks until release, and each repeat SHALL reload btn_sel per REQ-018.
REQ-024 Without BTN_DEBOUNCE_AUTOREPEAT_EN, exactly one btn_press pulse SHALL occur per accepted press, and the repeat counters SHALL NOT be synthesised.

Structure
REQ-025 Package btn_debounce_pkg SHALL hold the state enum, the reset constant for btn_sel (4'b1110), and the repeat constants (500 and 100).
REQ-026 Per-channel logic (synchroniser, FSM, counter, repeat logic) SHALL be sub-module btn_debounce_ch, instantiated four times; the prescaler and btn_sel priority logic stay in the top.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-027 Reset, all inputs 1 -> btn_db=1111, btn_press=0000, btn_sel=1110; hold unchanged for 100 cycles.
REQ-028 btn_raw[2] low steadily -> one btn_press[2] pulse within 2+12+1 cycles, btn_db=1011, btn_sel=1011; release -> btn_db=1111, btn_sel stays 1011.
REQ-029 btn_raw[1] low for 6 cycles, then high -> no output change ever.
REQ-030 btn_raw[3] and btn_raw[1] low on the same cycle -> both press bits pulse on the same cycle, btn_sel=1101.
REQ-031 RST pulsed one cycle while btn_raw[0] is mid-PRESS_CHK and still held -> btn_press[0] pulses 3 ticks after reset release, btn_sel=1110.
REQ-032 With BTN_DEBOUNCE_AUTOREPEAT_EN, hold btn_raw[1] for 800 ticks -> pulses at acceptance, +500 ticks, +600 ticks and +700 ticks (4 total); without the macro -> exactly 1.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared types and constants for the four-channel button debouncer
//
// Contents:
//   ch_state_t    per-channel debounce state
//   SEL_RESET     btn_sel value after reset (channel 0 selected)
//   REPEAT_FIRST  ticks from acceptance to the first auto-repeat pulse
//   REPEAT_NEXT   ticks between subsequent auto-repeat pulses
//   sel_code()    one-cold selection word for the lowest pressed channel

package btn_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } ch_state_t;

  localparam logic [3:0]  SEL_RESET    = 4'b1110;
  localparam int unsigned REPEAT_FIRST = 500;
  localparam int unsigned REPEAT_NEXT  = 100;
  localparam int          REPEAT_W     = 9;

  // Walk from the top index down so the lowest set bit wins.
  function automatic logic [3:0] sel_code(input logic [3:0] press);
    logic [3:0] one;
    logic [3:0] code;
    one  = 4'b0001;
    code = SEL_RESET;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) code = ~(one << i);
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - button bundle between the pad side and the debouncer
//
// Signals:
//   btn_raw    raw pushbuttons, active-low, asynchronous
//   btn_db     debounced levels, active-low
//   btn_press  one-cycle press pulses, active-high
//   btn_sel    latched one-cold code of the last accepted press
// Modports:
//   master  drives btn_raw, observes the debounced outputs
//   slave   the debouncer itself

interface btn_debounce_if;
  logic [3:0] btn_raw;
  logic [3:0] btn_db;
  logic [3:0] btn_press;
  logic [3:0] btn_sel;

  modport master (output btn_raw, input btn_db, input btn_press, input btn_sel);
  modport slave  (input btn_raw, output btn_db, output btn_press, output btn_sel);
endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one debounce channel: synchroniser, state machine, stability counter
//
// Ports:
//   CLK    system clock, rising edge
//   RST    synchronous active-high reset
//   tick   one-cycle sample strobe from the shared prescaler
//   raw    raw button, active-low, asynchronous
//   db     debounced level, active-low, registered
//   press  one-cycle pulse after the tick that accepts a press
// Build option: BTN_DEBOUNCE_AUTOREPEAT_EN adds auto-repeat pulses while held.

module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic press
);

  localparam logic [7:0] STABLE = 8'(STABLE_TICKS);

  logic      sync_1;
  logic      sync_2;
  ch_state_t state;
  ch_state_t state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic      accept;
  logic      press_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      state  <= RELEASED;
      cnt    <= 8'd0;
      db     <= 1'b1;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      // Decode from the next state so db lines up with the state register.
      db     <= !(state_nxt == PRESSED || state_nxt == RELEASE_CHK);
      press  <= press_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        RELEASED: begin
          if (!sync_2) begin
            cnt_nxt   = 8'd1;
            state_nxt = PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (!sync_2) begin
            cnt_nxt = cnt + 8'd1;
            if (cnt_nxt == STABLE) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end
          end else begin
            cnt_nxt   = 8'd0;
            state_nxt = RELEASED;
          end
        end
        PRESSED: begin
          if (sync_2) begin
            cnt_nxt   = 8'd1;
            state_nxt = RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (sync_2) begin
            cnt_nxt = cnt + 8'd1;
            if (cnt_nxt == STABLE) state_nxt = RELEASED;
          end else begin
            cnt_nxt   = 8'd0;
            state_nxt = PRESSED;
          end
        end
        default: begin
          cnt_nxt   = 8'd0;
          state_nxt = RELEASED;
        end
      endcase
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  logic [REPEAT_W-1:0] rep_cnt;
  logic                rep_first_done;
  logic                rep_held;
  logic                rep_hit;

  // Only ticks that confirm the button is still down advance the repeat timer.
  assign rep_held = tick && (state == PRESSED) && !sync_2;
  assign rep_hit  = rep_held &&
                    ((rep_cnt + REPEAT_W'(1)) ==
                     (rep_first_done ? REPEAT_W'(REPEAT_NEXT) : REPEAT_W'(REPEAT_FIRST)));

  always_ff @(posedge CLK) begin
    if (RST || accept) begin
      rep_cnt        <= '0;
      rep_first_done <= 1'b0;
    end else if (rep_hit) begin
      rep_cnt        <= '0;
      rep_first_done <= 1'b1;
    end else if (rep_held) begin
      rep_cnt <= rep_cnt + REPEAT_W'(1);
    end
  end

  assign press_nxt = accept | rep_hit;
`else
  assign press_nxt = accept;
`endif

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - four-channel pushbutton debouncer with press pulses and selection latch
//
// Ports:
//   CLK   system clock, rising edge
//   RST   synchronous active-high reset
//   bus   btn_debounce_if.slave: btn_raw in; btn_db, btn_press, btn_sel out
// Parameters:
//   TICK_DIV      CLK cycles per sample tick (2..2^20)
//   STABLE_TICKS  equal consecutive samples to accept a level change (2..255)
// Build option: BTN_DEBOUNCE_AUTOREPEAT_EN enables auto-repeat in each channel.

module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic           CLK,
  input  logic           RST,
  btn_debounce_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    db;
  logic [3:0]    press;
  logic [3:0]    sel;

  // Tick is the last prescaler count, i.e. the cycle on which it wraps to 0.
  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .raw  (bus.btn_raw[i]),
      .db   (db[i]),
      .press(press[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel <= SEL_RESET;
    end else if (|press) begin
      sel <= sel_code(press);
    end
  end

  assign bus.btn_db    = db;
  assign bus.btn_press = press;
  assign bus.btn_sel   = sel;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce (TICK_DIV=4, STABLE_TICKS=3)

module tb_btn_debounce;

  typedef struct {
    logic [3:0] db;
    logic [3:0] press;
    logic [3:0] sel;
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  btn_debounce_if bus ();

  btn_debounce #(
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int  cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  ev_count    = 0;
  int  last_ev_cyc = 0;
  bit  mon_en      = 1'b0;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int HOLD_PULSES = 4;
`else
  localparam int HOLD_PULSES = 1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] db, input logic [3:0] press, input logic [3:0] sel);
    ev_t e;
    e.db = db;
    e.press = press;
    e.sel = sel;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name, input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge CLK);
      k++;
    end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected events outstanding after %0d cycles, expected 0",
               name, exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  // Monitor: any press pulse or debounced level change is an output event.
  initial begin
    logic [3:0] prev_db;
    ev_t got;
    ev_t e;
    prev_db = 4'hF;
    forever begin
      @(negedge CLK);
      if (!mon_en || RST) begin
        prev_db = bus.btn_db;
      end else if (bus.btn_press != 4'h0 || bus.btn_db != prev_db) begin
        got.db = bus.btn_db;
        got.press = bus.btn_press;
        last_ev_cyc = cyc;
        ev_count++;
        @(negedge CLK);
        got.sel = bus.btn_sel;
        prev_db = bus.btn_db;
        check("press_one_cycle", 32'(bus.btn_press & got.press), 32'h0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got db=%b press=%b sel=%b, expected no event",
                   got.db, got.press, got.sel);
        end else begin
          e = exp_q.pop_front();
          check("event_db", 32'(got.db), 32'(e.db));
          check("event_press", 32'(got.press), 32'(e.press));
          check("event_sel", 32'(got.sel), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int d;
    int lat;
    int rel;

    bus.btn_raw = 4'hF;
    RST = 1'b1;
    cycles(3);
    check("reset_db", 32'(bus.btn_db), 32'hF);
    check("reset_press", 32'(bus.btn_press), 32'h0);
    check("reset_sel", 32'(bus.btn_sel), 32'hE);
    RST = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: outputs hold.
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      check("idle_hold", 32'({bus.btn_db, bus.btn_press, bus.btn_sel}), 32'hF0E);
    end
    cycles(1);

    // Single press on channel 2, then release.
    e0 = ev_count;
    d = cyc;
    push(4'b1011, 4'b0100, 4'b1011);
    bus.btn_raw = 4'b1011;
    drain("press2", 40);
    lat = last_ev_cyc - d;
    check("press2_latency_in_11_to_15", 32'(lat >= 11 && lat <= 15), 32'd1);
    check("press2_events", 32'(ev_count - e0), 32'd1);
    push(4'b1111, 4'b0000, 4'b1011);
    bus.btn_raw = 4'hF;
    drain("release2", 40);
    cycles(10);
    check("release2_sel_held", 32'(bus.btn_sel), 32'hB);

    // Short glitch on channel 1: nothing happens.
    e0 = ev_count;
    bus.btn_raw = 4'b1101;
    cycles(6);
    bus.btn_raw = 4'hF;
    cycles(40);
    check("glitch1_events", 32'(ev_count - e0), 32'd0);
    check("glitch1_outputs", 32'({bus.btn_db, bus.btn_press, bus.btn_sel}), 32'hF0B);

    // Simultaneous press of channels 3 and 1: lowest index wins btn_sel.
    push(4'b0101, 4'b1010, 4'b1101);
    bus.btn_raw = 4'b0101;
    drain("press31", 40);
    cycles(5);
    e0 = ev_count;
    bus.btn_raw = 4'hF;
    cycles(6);
    bus.btn_raw = 4'b0101;
    cycles(40);
    check("release_glitch_events", 32'(ev_count - e0), 32'd0);
    check("release_glitch_db", 32'(bus.btn_db), 32'h5);
    push(4'b1111, 4'b0000, 4'b1101);
    bus.btn_raw = 4'hF;
    drain("release31", 40);
    cycles(10);

    // Reset in the middle of a press check on channel 0.
    e0 = ev_count;
    bus.btn_raw = 4'b1110;
    cycles(8);
    check("mid_check_events", 32'(ev_count - e0), 32'd0);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    rel = cyc;
    check("post_reset_sel", 32'(bus.btn_sel), 32'hE);
    push(4'b1110, 4'b0001, 4'b1110);
    drain("press0_after_reset", 40);
    check("press0_reset_latency", 32'(last_ev_cyc - rel), 32'd12);
    push(4'b1111, 4'b0000, 4'b1110);
    bus.btn_raw = 4'hF;
    drain("release0", 40);
    cycles(10);

    // Long hold on channel 1 for 800 ticks.
    e0 = ev_count;
    for (int i = 0; i < HOLD_PULSES; i++) push(4'b1101, 4'b0010, 4'b1101);
    bus.btn_raw = 4'b1101;
    cycles(3200);
    check("hold_pulse_count", 32'(ev_count - e0), 32'(HOLD_PULSES));
    push(4'b1111, 4'b0000, 4'b1101);
    bus.btn_raw = 4'hF;
    drain("release_hold", 40);
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
